load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the execute stage and `data_memory`. It turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the memory's single-word port. It does byte-lane extraction, sign and zero extension, and read-modify-write for sub-word stores, since `data_memory` only writes whole words. It uses a valid/ready request handshake toward the core and a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width driven to `data_memory`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  the core presents a request.
- `req_ready`  out  1  the unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle pulse marking completion.
- `resp_rdata`  out  32  extended load result; 0 for stores.
- `resp_err`  out  1  qualifies `resp_valid`: illegal funct3, or misaligned access when checking is enabled.
- `mem_address`  out  ADDR_W  to `data_memory.address`.
- `mem_wr_en`  out  1  to `data_memory.wr_en`.
- `mem_wr_data`  out  32  to `data_memory.wr_data`.
- `mem_rd_data`  in  32  from `data_memory.rd_data`; combinational read of `mem_address`.

## Operation
- A request is accepted when `req_valid && req_ready` at a rising edge. All request fields are latched at that edge.
- Word address is `req_addr[ADDR_W+1:2]`. Upper address bits are ignored, so accesses alias.
- FSM states are IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: `req_ready` = 1. On accept:
  - error request -> RESP with `resp_err` set;
  - load -> LOAD;
  - SW -> WRITE;
  - SB/SH -> RMW_RD.
- LOAD: drive `mem_address`. Register the extracted and extended value from `mem_rd_data` into `resp_rdata`. Next state RESP.
- RMW_RD: drive `mem_address` and capture `mem_rd_data` as the old word. Next state WRITE.
- WRITE: `mem_wr_en` = 1 for exactly this cycle, with the merged word. Next state RESP.
  - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`.
  - SH replaces half-word lane `addr[1]` with `wdata[15:0]`.
  - SW writes `wdata` unmodified.
- RESP: `resp_valid` = 1 for one cycle. Next state IDLE. The core never back-pressures responses.
- Extension:
  - LB and LH sign-extend bit 7 or bit 15 of the selected lane.
  - LBU and LHU zero-extend.
  - LW returns the word unmodified.
- Illegal funct3 (011, 110, 111; also 100 or 101 with `req_we` = 1) gives an error response and no memory access.
- `mem_address` holds the latched word address in every non-IDLE state.
- `mem_wr_data` is meaningful only while `mem_wr_en` is high.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready` = 0 while `rst` is high, and 1 on the first cycle after;
  - `resp_valid`, `resp_err` and `mem_wr_en` = 0;
  - `resp_rdata`, `mem_address` and `mem_wr_data` = 0.
- Latency from accept edge to the `resp_valid` cycle:
  - error: 1 cycle;
  - load and SW: 2 cycles;
  - SB and SH: 3 cycles.
- `req_ready` is low from the accept cycle until the state returns to IDLE, so the unit has no back-to-back overlap. The next accept is possible in the cycle after RESP.
- `resp_rdata` and `resp_err` hold their values until the next response.
- A `rst` asserted in any state returns the FSM to IDLE on that edge and drops `mem_wr_en`.
  - Reset in RMW_RD leaves memory unmodified.
  - A `rst` coinciding with WRITE wins, and the write does not occur.
  - No response is produced for a request aborted by reset.
- A `req_valid` asserted during reset is ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: an access is misaligned when a halfword has `addr[0]` = 1 or a word has `addr[1:0]` != 0.
  - A misaligned access produces an error response after 1 cycle.
  - It performs no memory access.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - offending low bits are forced to zero: halfword clears `addr[0]`, word clears `addr[1:0]`;
  - the access proceeds normally;
  - `resp_err` reports only illegal funct3.

## Structure
- `lsu_pkg` holds:
  - the funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the FSM state enum typedef `lsu_state_t`;
  - `ADDR_W` default.
- Sub-module `lsu_byte_lane` is purely combinational and has two functions:
  - load extract/extend from the word, funct3 and offset;
  - store merge from the old word, wdata, funct3 and offset.
- `load_store_unit` holds the FSM, the request latch and the registered outputs.

## Test plan
- SW 0xDEADBEEF to 0x28 -> `mem_wr_en` for 1 cycle at address 10; `resp_valid` 2 cycles after accept; then LW 0x28 -> 0xDEADBEEF.
- With word 10 = 0xDEADBEEF:
  - LB 0x2B -> 0xFFFFFFDE;
  - LBU 0x2B -> 0x000000DE;
  - LH 0x28 -> 0xFFFFBEEF;
  - LHU 0x2A -> 0x0000DEAD.
- SB 0x29 with wdata 0x00000055 -> one read cycle then a write of 0xDEAD55EF; response 3 cycles after accept; `req_ready` low throughout.
- LW 0x2A:
  - with `LSU_MISALIGN_CHECK_EN`: `resp_err` = 1 after 1 cycle and `mem_wr_en` never high;
  - without it: returns word 10.
- SH 0x50 with 0xAAAA and word 20 = 0x12345678, `rst` pulsed in RMW_RD -> no `mem_wr_en`, no `resp_valid`, and word 20 reads back 0x12345678.
- funct3 = 011 load -> `resp_err` = 1 after 1 cycle with no memory access; a new request is accepted on the following cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

  localparam int LSU_ADDR_W = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_t;

  // Unsigned widths exist only for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise a missed path infers a latch.
    byte_sel = mem_word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? mem_word[31:16] : mem_word[15:0];

    load_data = mem_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = mem_word;
    endcase

    store_data = mem_word;
    case (funct3)
      F3_B: store_data[{offset, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (offset[1]) store_data[31:16] = wdata[15:0];
        else           store_data[15:0]  = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a single-word data memory port.
// Define LSU_MISALIGN_CHECK_EN to turn misaligned H/W accesses into error responses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data
);

  lsu_state_t        state, state_next;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, wr_data_q, rdata_q;
  logic              err_q;

  logic        accept, req_err;
  logic [1:0]  req_off;
  logic [31:0] load_data, store_data;
  logic        addr_unused;

  // High address bits deliberately alias onto the memory.
  assign addr_unused = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_off = req_addr[1:0];
    req_err = !f3_legal(req_we, req_funct3);
`ifdef LSU_MISALIGN_CHECK_EN
    case (req_funct3[1:0])
      2'b01:   if (req_addr[0]) req_err = 1'b1;
      2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: ;
    endcase
`else
    case (req_funct3[1:0])
      2'b01:   req_off[0] = 1'b0;
      2'b10:   req_off    = 2'b00;
      default: ;
    endcase
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_next = RESP;
          else if (!req_we)            state_next = LOAD;
          else if (req_funct3 == F3_W) state_next = WRITE;
          else                         state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  lsu_byte_lane u_byte_lane (
    .mem_word   (mem_rd_data),
    .wdata      (wdata_q),
    .funct3     (f3_q),
    .offset     (off_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Response fields change only on the edge entering RESP, so they hold
  // between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q      <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        f3_q    <= req_funct3;
        off_q   <= req_off;
        addr_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        if (req_we && req_funct3 == F3_W) wr_data_q <= req_wdata;
        if (req_err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      case (state)
        LOAD: begin
          rdata_q <= load_data;
          err_q   <= 1'b0;
        end
        RMW_RD: wr_data_q <= store_data;
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A reset coinciding with WRITE or RESP suppresses the write and the response.
  assign mem_wr_en   = (state == WRITE) && !rst;
  assign resp_valid  = (state == RESP) && !rst;
  assign mem_address = addr_q;
  assign mem_wr_data = wr_data_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, scoreboard, reset corner cases.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic [31:0]       mem_rd_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Word memory model: combinational read, write committed once per wr_en cycle.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int wr_count   = 0;
  int resp_count = 0;
  int cycle      = 0;
  int tests      = 0;
  int fails      = 0;

  assign mem_rd_data = mem[mem_address];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    #1;
    if (mem_wr_en) begin
      mem[mem_address] <= mem_wr_data;
      wr_count         <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: resp_valid=1 with rdata %h, expected no response", resp_rdata);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_latency", 32'(cycle - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat, input bit expect_resp);
    int waited;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: req_ready=0 after %0d cycles, expected 1", waited);
      return;
    end
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    if (expect_resp) sb.push_back('{exp_rdata, exp_err, exp_lat, cycle + 1});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;

    //             we    f3     addr        wdata         rdata         err  lat nwr word
    vecs.push_back('{1'b1, F3_W,  32'h28,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF});
    vecs.push_back('{1'b0, F3_W,  32'h28,   32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b1, F3_W,  32'h30,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF});
    vecs.push_back('{1'b1, F3_W,  32'h50,   32'h12345678, 32'h0,        1'b0, 2, 1, 32'h12345678});
    vecs.push_back('{1'b1, F3_W,  32'h54,   32'h0BADF00D, 32'h0,        1'b0, 2, 1, 32'h0BADF00D});
    vecs.push_back('{1'b0, F3_B,  32'h2B,   32'h0,        32'hFFFFFFDE, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b0, F3_BU, 32'h2B,   32'h0,        32'h000000DE, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b0, F3_H,  32'h28,   32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b0, F3_HU, 32'h2A,   32'h0,        32'h0000DEAD, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b0, F3_B,  32'h28,   32'h0,        32'hFFFFFFEF, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b0, F3_BU, 32'h29,   32'h0,        32'h000000BE, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b1, F3_B,  32'h29,   32'h00000055, 32'h0,        1'b0, 3, 1, 32'hDEAD55EF});
    vecs.push_back('{1'b0, F3_W,  32'h28,   32'h0,        32'hDEAD55EF, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b1, F3_H,  32'h2A,   32'hFFFF1234, 32'h0,        1'b0, 3, 1, 32'h123455EF});
    vecs.push_back('{1'b0, F3_H,  32'h2A,   32'h0,        32'h00001234, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b0, F3_W,  32'h1028, 32'h0,        32'h123455EF, 1'b0, 2, 0, 32'h0});
`ifdef LSU_MISALIGN_CHECK_EN
    vecs.push_back('{1'b0, F3_W,  32'h2A,   32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
`else
    vecs.push_back('{1'b0, F3_W,  32'h2A,   32'h0,        32'h123455EF, 1'b0, 2, 0, 32'h0});
`endif
    vecs.push_back('{1'b0, 3'b011, 32'h28,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    vecs.push_back('{1'b1, F3_BU, 32'h28,   32'h11111111, 32'h0,        1'b1, 1, 0, 32'h0});
    vecs.push_back('{1'b0, 3'b110, 32'h28,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    vecs.push_back('{1'b0, F3_B,  32'h29,   32'h0,        32'h00000055, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b0, F3_HU, 32'h28,   32'h0,        32'h000055EF, 1'b0, 2, 0, 32'h0});
    vecs.push_back('{1'b1, F3_B,  32'h2B,   32'hFFFFFF80, 32'h0,        1'b0, 3, 1, 32'h803455EF});
    vecs.push_back('{1'b0, F3_B,  32'h2B,   32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h0});

    // Reset phase with a store request held high: it must be ignored.
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h14;
    req_wdata  = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check("rst_mem_wr_data", mem_wr_data, 32'h0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'h1);
    repeat (4) @(negedge clk);
    check("rst_req_ignored_writes", 32'(wr_count), 32'h0);
    check("rst_req_ignored_resps", 32'(resp_count), 32'h0);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      w0 = wr_count;
      start_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].rdata, vecs[i].err, vecs[i].lat, 1'b1);
      wait_done();
      check($sformatf("v%0d_writes", i), 32'(wr_count - w0), 32'(vecs[i].nwr));
      if (vecs[i].nwr > 0)
        check($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[ADDR_W+1:2]], vecs[i].word);
    end

    // SB cycle by cycle: one read cycle, one write cycle, then response.
    w0 = wr_count;
    start_req(1'b1, F3_B, 32'h31, 32'h00000055, 32'h0, 1'b0, 3, 1'b1);
    #1;
    check("sb_rd_ready", 32'(req_ready), 32'h0);
    check("sb_rd_wr_en", 32'(mem_wr_en), 32'h0);
    check("sb_rd_address", 32'(mem_address), 32'd12);
    @(negedge clk);
    #1;
    check("sb_wr_ready", 32'(req_ready), 32'h0);
    check("sb_wr_en", 32'(mem_wr_en), 32'h1);
    check("sb_wr_data", mem_wr_data, 32'hDEAD55EF);
    @(negedge clk);
    #1;
    check("sb_resp_ready", 32'(req_ready), 32'h0);
    wait_done();
    check("sb_write_count", 32'(wr_count - w0), 32'h1);
    check("sb_mem_word", mem[12], 32'hDEAD55EF);

    // Reset during RMW_RD: no write, no response, memory intact.
    w0 = wr_count;
    r0 = resp_count;
    start_req(1'b1, F3_H, 32'h50, 32'h0000AAAA, 32'h0, 1'b0, 3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rmw_rst_writes", 32'(wr_count - w0), 32'h0);
    check("rmw_rst_resps", 32'(resp_count - r0), 32'h0);
    check("rmw_rst_mem_word", mem[20], 32'h12345678);
    check("rmw_rst_ready", 32'(req_ready), 32'h1);
    start_req(1'b0, F3_W, 32'h50, 32'h0, 32'h12345678, 1'b0, 2, 1'b1);
    wait_done();

    // Reset coinciding with WRITE: the write is dropped.
    w0 = wr_count;
    r0 = resp_count;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h54;
    req_wdata  = 32'hCAFEF00D;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("wr_rst_accepted_addr", 32'(mem_address), 32'd21);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_rst_writes", 32'(wr_count - w0), 32'h0);
    check("wr_rst_resps", 32'(resp_count - r0), 32'h0);
    check("wr_rst_mem_word", mem[21], 32'h0BADF00D);

    // Illegal funct3 followed by an immediate new request.
    w0 = wr_count;
    start_req(1'b0, 3'b011, 32'h28, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    #1;
    check("illegal_resp_cycle_wr_en", 32'(mem_wr_en), 32'h0);
    @(negedge clk);
    #1;
    check("illegal_next_ready", 32'(req_ready), 32'h1);
    start_req(1'b0, F3_W, 32'h28, 32'h0, 32'h803455EF, 1'b0, 2, 1'b1);
    wait_done();
    check("illegal_writes", 32'(wr_count - w0), 32'h0);

    // Response fields hold while idle.
    repeat (3) @(negedge clk);
    #1;
    check("hold_rdata", resp_rdata, 32'h803455EF);
    check("hold_err", 32'(resp_err), 32'h0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
